// File: rtl/disp_scan_arb_pkg.sv
// rtl/disp_scan_arb_pkg.sv - shared segment codes, arbiter state type and nibble helper
package disp_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_B     = 8'h86;
    localparam logic [7:0] SEG_C     = 8'hAB;
    localparam logic [7:0] SEG_D     = 8'hA1;

    localparam logic [3:0] BLANK      = 4'hA;
    localparam int         NUM_DIGITS = 6;

    typedef enum logic {
        MAIN = 1'b0,
        OVL  = 1'b1
    } arb_state_t;

    // idx 0 is the leftmost digit, which lives in the top nibble
    function automatic logic [3:0] pick_nibble(input logic [23:0] data, input logic [2:0] idx);
        return 4'(data >> (4 * (NUM_DIGITS - 1 - int'(idx))));
    endfunction

endpackage

// File: rtl/disp_scan_arb_if.sv
// rtl/disp_scan_arb_if.sv - display data, overlay handshake and scan output bundle
interface disp_scan_arb_if;
    logic [23:0] main_data;
    logic [5:0]  main_blink;
    logic        ovl_req;
    logic [23:0] ovl_data;
    logic        ovl_gnt;
    logic [5:0]  sel;
    logic [7:0]  led;
    logic        scan_tick;

    modport master (
        output main_data, main_blink, ovl_req, ovl_data,
        input  ovl_gnt, sel, led, scan_tick
    );

    modport slave (
        input  main_data, main_blink, ovl_req, ovl_data,
        output ovl_gnt, sel, led, scan_tick
    );
endinterface

// File: rtl/disp_scan_arb_seg7_decode.sv
// rtl/disp_scan_arb_seg7_decode.sv - combinational nibble to active-low segment lookup
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/disp_scan_arb.sv
// rtl/disp_scan_arb.sv - six-digit scan controller with main/overlay display arbitration
module disp_scan_arb
    import disp_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int BLINK_DIV      = 25000000,
    parameter int OVL_MIN_FRAMES = 2
) (
    input  logic             clkin,
    input  logic             rst,
    disp_scan_arb_if.slave   bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int FW = (OVL_MIN_FRAMES < 2) ? 1 : $clog2(OVL_MIN_FRAMES + 1);

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [FW-1:0] FRAME_MIN  = FW'(OVL_MIN_FRAMES);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

    logic [SW-1:0] scan_cnt_q,    scan_cnt_d;
    logic [BW-1:0] blink_cnt_q,   blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [2:0]    digit_q,       digit_d;
    arb_state_t    state_q,       state_d;
    logic [FW-1:0] frame_cnt_q,   frame_cnt_d;
    logic [5:0]    sel_q,         sel_d;
    logic [7:0]    led_q,         led_d;
    logic          scan_tick_q,   scan_tick_d;

    logic          advance;
    logic [FW-1:0] frame_inc;
    logic [3:0]    nibble;
    logic [7:0]    seg;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            scan_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            digit_q       <= LAST_IDX;
            state_q       <= MAIN;
            frame_cnt_q   <= '0;
            sel_q         <= 6'h3F;
            led_q         <= SEG_BLANK;
            scan_tick_q   <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            digit_q       <= digit_d;
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            sel_q         <= sel_d;
            led_q         <= led_d;
            scan_tick_q   <= scan_tick_d;
        end
    end

    // Counters, digit index and arbiter; the arbiter only moves on the 6->1 advance
    always_comb begin
        advance       = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d    = advance ? '0 : scan_cnt_q + SW'(1);
        scan_tick_d   = (scan_cnt_d == SCAN_LAST);
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        digit_d       = digit_q;
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        frame_inc     = (frame_cnt_q == FRAME_MIN) ? frame_cnt_q : frame_cnt_q + FW'(1);

        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        if (advance) begin
            digit_d = (digit_q == LAST_IDX) ? 3'd0 : digit_q + 3'd1;
            if (digit_q == LAST_IDX) begin
                case (state_q)
                    MAIN: begin
                        if (bus.ovl_req) begin
                            state_d     = OVL;
                            frame_cnt_d = '0;
                        end
                    end
                    OVL: begin
                        frame_cnt_d = frame_inc;
                        if (!bus.ovl_req && frame_inc >= FRAME_MIN) state_d = MAIN;
                    end
                    default: state_d = MAIN;
                endcase
            end
        end
    end

    // Source follows the post-boundary owner so a frame is never split between owners
    assign nibble = pick_nibble((state_d == OVL) ? bus.ovl_data : bus.main_data, digit_d);

    seg7_decode u_decode (
        .nibble (nibble),
        .seg    (seg)
    );

    always_comb begin
        sel_d = sel_q;
        led_d = led_q;
        if (advance) begin
            sel_d = ~(6'b100000 >> digit_d);
            if (state_d == MAIN && bus.main_blink[LAST_IDX - digit_d] && !blink_phase_q)
                led_d = SEG_BLANK;
            else
                led_d = seg;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.led       = led_q;
    assign bus.scan_tick = scan_tick_q;
    assign bus.ovl_gnt   = (state_q == OVL);

endmodule

// File: tb/tb_disp_scan_arb.sv
// tb/tb_disp_scan_arb.sv - directed bench with cycle model of the scan arbiter
module tb_disp_scan_arb;
    localparam int SD   = 4;
    localparam int BD   = 64;
    localparam int MINF = 2;
    localparam logic [7:0] SEG_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                            8'h80, 8'h90, 8'hFF, 8'h86, 8'hAB, 8'hA1, 8'hFF, 8'hFF};

    logic clkin = 1'b0;
    logic rst   = 1'b1;
    always #5 clkin = ~clkin;

    disp_scan_arb_if bus ();

    disp_scan_arb #(.SCAN_DIV(SD), .BLINK_DIV(BD), .OVL_MIN_FRAMES(MINF)) dut (
        .clkin (clkin),
        .rst   (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: cycle c since reset; digit slots are SD cycles; phase visible in even BD periods
    int          m_cyc;
    bit          m_ovl;
    int          m_frames;
    logic [5:0]  m_sel;
    logic [7:0]  m_led;
    bit          m_tick;
    int          m_k, m_d;
    bit          m_vis;
    logic [23:0] m_src;
    logic [3:0]  m_nib;

    always @(posedge clkin or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_ovl = 0; m_frames = 0;
            m_sel = 6'h3F; m_led = 8'hFF; m_tick = 0;
        end else begin
            if (m_cyc % SD == SD - 1) begin
                m_k   = (m_cyc + 1) / SD;
                m_d   = (m_k - 1) % 6 + 1;
                m_vis = ((m_cyc / BD) % 2) == 0;
                if (m_d == 1) begin
                    if (!m_ovl) begin
                        if (bus.ovl_req) begin m_ovl = 1; m_frames = 0; end
                    end else begin
                        m_frames++;
                        if (!bus.ovl_req && m_frames >= MINF) m_ovl = 0;
                    end
                end
                m_src = m_ovl ? bus.ovl_data : bus.main_data;
                m_nib = 4'(m_src >> (4 * (6 - m_d)));
                m_sel = 6'h3F ^ (6'h01 << (6 - m_d));
                m_led = (!m_ovl && bus.main_blink[6 - m_d] && !m_vis) ? 8'hFF : SEG_TAB[m_nib];
            end
            m_cyc++;
            m_tick = (m_cyc % SD == SD - 1);
        end
    end

    always @(negedge clkin) begin
        if (rst) begin
            check("rst_sel", 32'(bus.sel), 32'h3F);
            check("rst_led", 32'(bus.led), 32'hFF);
            check("rst_gnt", 32'(bus.ovl_gnt), 32'h0);
        end else begin
            check("model_sel",  32'(bus.sel),       32'(m_sel));
            check("model_led",  32'(bus.led),       32'(m_led));
            check("model_gnt",  32'(bus.ovl_gnt),   32'(m_ovl));
            check("model_tick", 32'(bus.scan_tick), 32'(m_tick));
        end
    end

    // Returns at posedge+1 just after the next digit advance
    task automatic next_slot();
        bit found = 0;
        for (int i = 0; i < 2 * SD + 2; i++) begin
            @(negedge clkin);
            if (bus.scan_tick) begin
                @(posedge clkin);
                #1;
                found = 1;
                break;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL slot_timeout: got no scan_tick expected one within %0d cycles", 2 * SD + 2);
        end
    endtask

    logic [5:0] exp_sel [6] = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};
    logic [7:0] exp_t1  [6] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    logic [7:0] exp_t3  [6] = '{8'hFF, 8'hFF, 8'h86, 8'hAB, 8'hA1, 8'hFF};
    logic [7:0] exp_t6  [6] = '{8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF};

    initial begin
        bit saw_on, saw_off, bad_other;
        bus.main_data  = 24'h123456;
        bus.main_blink = 6'b000000;
        bus.ovl_req    = 1'b0;
        bus.ovl_data   = 24'h000000;
        repeat (3) @(posedge clkin);
        #1;
        check("t0_tick", 32'(bus.scan_tick), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            next_slot();
            check("t1_sel", 32'(bus.sel), 32'(exp_sel[i]));
            check("t1_led", 32'(bus.led), 32'(exp_t1[i]));
        end

        bus.main_blink = 6'b000001;
        saw_on = 0; saw_off = 0; bad_other = 0;
        for (int i = 0; i < 40; i++) begin
            next_slot();
            if (bus.sel == 6'h3E) begin
                if (bus.led == 8'h82) saw_on = 1;
                if (bus.led == 8'hFF) saw_off = 1;
            end else if (bus.led == 8'hFF) bad_other = 1;
        end
        check("t2_on",    32'(saw_on),    32'h1);
        check("t2_off",   32'(saw_off),   32'h1);
        check("t2_other", 32'(bad_other), 32'h0);

        bus.main_blink = 6'h3F;
        for (int i = 0; i < 12 && bus.sel != 6'h37; i++) next_slot();
        check("t3_at_d3", 32'(bus.sel), 32'h37);
        bus.ovl_req  = 1'b1;
        bus.ovl_data = 24'hAABCDA;
        for (int i = 0; i < 3; i++) begin
            next_slot();
            check("t3_pre_gnt", 32'(bus.ovl_gnt), 32'h0);
        end
        for (int i = 0; i < 6; i++) begin
            next_slot();
            check("t3_gnt", 32'(bus.ovl_gnt), 32'h1);
            check("t3_sel", 32'(bus.sel), 32'(exp_sel[i]));
            check("t3_led", 32'(bus.led), 32'(exp_t3[i]));
            if (i == 0) begin
                bus.ovl_req    = 1'b0;
                bus.main_blink = 6'b000000;
            end
        end

        next_slot();
        check("t4_frame2_gnt", 32'(bus.ovl_gnt), 32'h1);
        check("t4_frame2_led", 32'(bus.led), 32'hFF);
        for (int i = 0; i < 6; i++) next_slot();
        check("t4_drop_gnt", 32'(bus.ovl_gnt), 32'h0);
        check("t4_drop_sel", 32'(bus.sel), 32'h1F);
        check("t4_drop_led", 32'(bus.led), 32'hF9);

        bus.ovl_req = 1'b1;
        for (int i = 0; i < 24 && !(bus.ovl_gnt && bus.sel == 6'h3B); i++) next_slot();
        check("t5_at_ovl_d4", 32'({bus.ovl_gnt, bus.sel}), 32'h7B);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_sel", 32'(bus.sel), 32'h3F);
        check("t5_async_led", 32'(bus.led), 32'hFF);
        check("t5_async_gnt", 32'(bus.ovl_gnt), 32'h0);
        bus.ovl_req = 1'b0;
        @(posedge clkin);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clkin);
        #1;
        check("t5_wait_sel", 32'(bus.sel), 32'h3F);
        @(posedge clkin);
        #1;
        check("t5_first_sel", 32'(bus.sel), 32'h1F);
        check("t5_first_led", 32'(bus.led), 32'hF9);

        bus.main_data = 24'hEF0000;
        for (int i = 0; i < 6; i++) begin
            next_slot();
            check("t6_sel", 32'(bus.sel), 32'(exp_sel[(i + 1) % 6]));
            check("t6_led", 32'(bus.led), 32'(exp_t6[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
